// File: rtl/sm83_decode.sv
// -----------------------------------------------------------------------------
// sm83_pkg / sm83_decode
//
// Instruction register and opcode decoder sitting directly in front of the
// control sequencer. The opcode byte is captured from the memory data bus on
// every accepted fetch cycle. A registered ctl_op plus r8 operand selects are
// then presented to the sequencer and register file. The block tracks the CB
// prefix, HALT and illegal-opcode lockup so that the sequencer sees exactly one
// ctl_op per instruction.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous, active-high reset
//   fetch_cycle  mem_rdata carries the next opcode byte this cycle
//   mem_rdata    memory read data bus (8 bits)
//   irq_wake     single-cycle wake request, leaves HALTED
//   ctl_op       decoded operation (sm83_pkg::ctl_op_t)
//   r8_dst       destination r8 index (B,C,D,E,H,L,(HL),A = 0..7)
//   r8_src       source r8 index, same encoding
//   cb_mode      high while ctl_op = CTL_CB_OP
//   opcode_q     raw instruction register contents
//   halted       high in the HALTED state
//   illegal      sticky illegal-opcode flag
//
// Build option:
//   SM83_ILLEGAL_TRAP_EN  When defined, the eleven unused opcodes lock the
//                         decoder (CTL_ILLEGAL, illegal=1) until reset. When
//                         undefined, they decode as CTL_NOP and illegal is 0.
// -----------------------------------------------------------------------------

package sm83_pkg;
   typedef enum logic [2:0] {
      CTL_NOP       = 3'd0,
      CTL_LD_R8_D8  = 3'd1,
      CTL_LD_R8_R8  = 3'd2,
      CTL_HALT      = 3'd3,
      CTL_PREFIX_CB = 3'd4,
      CTL_CB_OP     = 3'd5,
      CTL_ILLEGAL   = 3'd6
   } ctl_op_t;
endpackage

module sm83_decode
   import sm83_pkg::*;
#(
   parameter logic [7:0] RESET_OPCODE = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch_cycle,
   input  logic [7:0] mem_rdata,
   input  logic       irq_wake,
   output ctl_op_t    ctl_op,
   output logic [2:0] r8_dst,
   output logic [2:0] r8_src,
   output logic       cb_mode,
   output logic [7:0] opcode_q,
   output logic       halted,
   output logic       illegal
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_CB_WAIT = 2'd1,
      ST_HALTED  = 2'd2
`ifdef SM83_ILLEGAL_TRAP_EN
      , ST_LOCKED = 2'd3
`endif
   } state_t;

   state_t     state_q, state_d;
   ctl_op_t    op_q, op_d;
   logic [7:0] ir_q, ir_d;
   logic [2:0] dst_q, dst_d;
   logic [2:0] src_q, src_d;
   logic       cb_q, cb_d;
   logic       halt_q, halt_d;
`ifdef SM83_ILLEGAL_TRAP_EN
   logic       ill_q, ill_d;

   // Unused SM83 opcode slots; executing one of them hangs the real part.
   function automatic logic is_illegal(input logic [7:0] op);
      case (op)
         8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
         8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_illegal = 1'b1;
         default:                           is_illegal = 1'b0;
      endcase
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         op_q    <= CTL_NOP;
         ir_q    <= RESET_OPCODE;
         dst_q   <= 3'd0;
         src_q   <= 3'd0;
         cb_q    <= 1'b0;
         halt_q  <= 1'b0;
`ifdef SM83_ILLEGAL_TRAP_EN
         ill_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ir_q    <= ir_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         cb_q    <= cb_d;
         halt_q  <= halt_d;
`ifdef SM83_ILLEGAL_TRAP_EN
         ill_q   <= ill_d;
`endif
      end
   end

   always_comb begin
      // Everything holds unless a fetch or wake is accepted.
      state_d = state_q;
      op_d    = op_q;
      ir_d    = ir_q;
      dst_d   = dst_q;
      src_d   = src_q;
      cb_d    = cb_q;
      halt_d  = halt_q;
`ifdef SM83_ILLEGAL_TRAP_EN
      ill_d   = ill_q;
`endif
      case (state_q)
         ST_RUN: begin
            if (fetch_cycle) begin
               ir_d = mem_rdata;
               cb_d = 1'b0;
               // 0x76 sits inside the 01dddsss block (LD (HL),(HL)), so it must be tested first.
               if (mem_rdata == 8'h76) begin
                  op_d    = CTL_HALT;
                  halt_d  = 1'b1;
                  state_d = ST_HALTED;
               end else if (mem_rdata[7:6] == 2'b01) begin
                  op_d  = CTL_LD_R8_R8;
                  dst_d = mem_rdata[5:3];
                  src_d = mem_rdata[2:0];
               end else if (mem_rdata[7:6] == 2'b00 && mem_rdata[2:0] == 3'b110) begin
                  op_d  = CTL_LD_R8_D8;
                  dst_d = mem_rdata[5:3];
               end else if (mem_rdata == 8'hCB) begin
                  op_d    = CTL_PREFIX_CB;
                  state_d = ST_CB_WAIT;
`ifdef SM83_ILLEGAL_TRAP_EN
               end else if (is_illegal(mem_rdata)) begin
                  op_d    = CTL_ILLEGAL;
                  ill_d   = 1'b1;
                  state_d = ST_LOCKED;
`endif
               end else begin
                  op_d = CTL_NOP;
               end
            end
         end
         ST_CB_WAIT: begin
            // Every CB-page opcode names its r8 operand in bits [2:0].
            if (fetch_cycle) begin
               ir_d    = mem_rdata;
               op_d    = CTL_CB_OP;
               cb_d    = 1'b1;
               dst_d   = mem_rdata[2:0];
               src_d   = mem_rdata[2:0];
               state_d = ST_RUN;
            end
         end
         ST_HALTED: begin
            // A fetch coinciding with the wake is dropped.
            if (irq_wake) begin
               op_d    = CTL_NOP;
               halt_d  = 1'b0;
               state_d = ST_RUN;
            end
         end
         default: begin
            // LOCKED: everything held until reset.
         end
      endcase
   end

   assign ctl_op   = op_q;
   assign r8_dst   = dst_q;
   assign r8_src   = src_q;
   assign cb_mode  = cb_q;
   assign opcode_q = ir_q;
   assign halted   = halt_q;
`ifdef SM83_ILLEGAL_TRAP_EN
   assign illegal  = ill_q;
`else
   assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_decode.sv
// -----------------------------------------------------------------------------
// tb_sm83_decode
//
// Directed, table-driven bench for sm83_decode. Each table row is one clock
// of stimulus plus the full expected output set after that edge. A short
// hand-written sequence follows for a long HALT with noisy fetches.
// Honours SM83_ILLEGAL_TRAP_EN for the illegal-opcode rows.
// -----------------------------------------------------------------------------

module tb_sm83_decode;
   import sm83_pkg::*;

   logic       clk;
   logic       rst;
   logic       fetch_cycle;
   logic [7:0] mem_rdata;
   logic       irq_wake;
   ctl_op_t    ctl_op;
   logic [2:0] r8_dst;
   logic [2:0] r8_src;
   logic       cb_mode;
   logic [7:0] opcode_q;
   logic       halted;
   logic       illegal;

   sm83_decode #(.RESET_OPCODE(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_cycle (fetch_cycle),
      .mem_rdata   (mem_rdata),
      .irq_wake    (irq_wake),
      .ctl_op      (ctl_op),
      .r8_dst      (r8_dst),
      .r8_src      (r8_src),
      .cb_mode     (cb_mode),
      .opcode_q    (opcode_q),
      .halted      (halted),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       fetch;
      logic       wake;
      logic [7:0] data;
      ctl_op_t    op;
      logic [2:0] dst;
      logic [2:0] src;
      logic       cb;
      logic       hlt;
      logic       ill;
      logic [7:0] opq;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic vec_t mk(input logic r, input logic f, input logic w,
                               input logic [7:0] d, input ctl_op_t op,
                               input logic [2:0] dst, input logic [2:0] src,
                               input logic cb, input logic hlt, input logic ill,
                               input logic [7:0] opq);
      vec_t v;
      v.rst = r; v.fetch = f; v.wake = w; v.data = d; v.op = op;
      v.dst = dst; v.src = src; v.cb = cb; v.hlt = hlt; v.ill = ill; v.opq = opq;
      return v;
   endfunction

   task automatic drive(input logic r, input logic f, input logic w, input logic [7:0] d);
      rst = r; fetch_cycle = f; irq_wake = w; mem_rdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input vec_t v);
      logic [19:0] act, exp;
      act = {ctl_op, r8_dst, r8_src, cb_mode, halted, illegal, opcode_q};
      exp = {v.op, v.dst, v.src, v.cb, v.hlt, v.ill, v.opq};
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got op=%0d dst=%0d src=%0d cb=%0b hlt=%0b ill=%0b opq=%02h, want op=%0d dst=%0d src=%0d cb=%0b hlt=%0b ill=%0b opq=%02h",
                    name, ctl_op, r8_dst, r8_src, cb_mode, halted, illegal, opcode_q,
                    v.op, v.dst, v.src, v.cb, v.hlt, v.ill, v.opq);
   endtask

   initial begin
      rst = 1'b1; fetch_cycle = 1'b0; irq_wake = 1'b0; mem_rdata = 8'h00;

      //              rst  fet  wak  data   op             dst  src  cb   hlt  ill  opq
      vecs.push_back(mk(1, 0, 0, 8'h00, CTL_NOP,       0, 0, 0, 0, 0, 8'h00)); // reset
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_LD_R8_D8,  0, 0, 0, 0, 0, 8'h06)); // LD B,d8
      vecs.push_back(mk(0, 1, 0, 8'h3E, CTL_LD_R8_D8,  7, 0, 0, 0, 0, 8'h3E)); // LD A,d8
      vecs.push_back(mk(0, 1, 0, 8'h7B, CTL_LD_R8_R8,  7, 3, 0, 0, 0, 8'h7B)); // LD A,E
      vecs.push_back(mk(0, 1, 0, 8'h41, CTL_LD_R8_R8,  0, 1, 0, 0, 0, 8'h41)); // LD B,C back-to-back
      vecs.push_back(mk(0, 0, 0, 8'h3E, CTL_LD_R8_R8,  0, 1, 0, 0, 0, 8'h41)); // no fetch: hold
      vecs.push_back(mk(0, 1, 0, 8'h00, CTL_NOP,       0, 1, 0, 0, 0, 8'h00)); // NOP keeps r8
      vecs.push_back(mk(0, 1, 0, 8'h76, CTL_HALT,      0, 1, 0, 1, 0, 8'h76)); // HALT
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_HALT,      0, 1, 0, 1, 0, 8'h76)); // ignored
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_HALT,      0, 1, 0, 1, 0, 8'h76)); // ignored
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_HALT,      0, 1, 0, 1, 0, 8'h76)); // ignored
      vecs.push_back(mk(0, 0, 1, 8'h06, CTL_NOP,       0, 1, 0, 0, 0, 8'h76)); // wake
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_LD_R8_D8,  0, 1, 0, 0, 0, 8'h06)); // normal again
      vecs.push_back(mk(0, 0, 1, 8'h00, CTL_LD_R8_D8,  0, 1, 0, 0, 0, 8'h06)); // wake in RUN: no effect
      vecs.push_back(mk(0, 1, 0, 8'hCB, CTL_PREFIX_CB, 0, 1, 0, 0, 0, 8'hCB)); // prefix
      vecs.push_back(mk(0, 0, 0, 8'h00, CTL_PREFIX_CB, 0, 1, 0, 0, 0, 8'hCB)); // wait
      vecs.push_back(mk(0, 0, 1, 8'h00, CTL_PREFIX_CB, 0, 1, 0, 0, 0, 8'hCB)); // wake in CB_WAIT
      vecs.push_back(mk(0, 1, 0, 8'h37, CTL_CB_OP,     7, 7, 1, 0, 0, 8'h37)); // SWAP A
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_LD_R8_D8,  0, 7, 0, 0, 0, 8'h06)); // cb_mode clears
      vecs.push_back(mk(0, 1, 0, 8'hCB, CTL_PREFIX_CB, 0, 7, 0, 0, 0, 8'hCB)); // prefix
      vecs.push_back(mk(1, 1, 0, 8'h11, CTL_NOP,       0, 0, 0, 0, 0, 8'h00)); // reset beats fetch
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_LD_R8_D8,  0, 0, 0, 0, 0, 8'h06)); // no stale prefix
      vecs.push_back(mk(0, 1, 0, 8'h76, CTL_HALT,      0, 0, 0, 1, 0, 8'h76)); // HALT
      vecs.push_back(mk(0, 1, 1, 8'h3E, CTL_NOP,       0, 0, 0, 0, 0, 8'h76)); // wake+fetch: byte dropped
      vecs.push_back(mk(0, 1, 0, 8'h3E, CTL_LD_R8_D8,  7, 0, 0, 0, 0, 8'h3E));
      vecs.push_back(mk(0, 1, 0, 8'h76, CTL_HALT,      7, 0, 0, 1, 0, 8'h76));
      vecs.push_back(mk(1, 0, 0, 8'h00, CTL_NOP,       0, 0, 0, 0, 0, 8'h00)); // reset from HALTED
      vecs.push_back(mk(0, 1, 0, 8'hCB, CTL_PREFIX_CB, 0, 0, 0, 0, 0, 8'hCB));
      vecs.push_back(mk(0, 1, 0, 8'hCB, CTL_CB_OP,     3, 3, 1, 0, 0, 8'hCB)); // CB CB = SET 1,E
      vecs.push_back(mk(0, 1, 0, 8'hCB, CTL_PREFIX_CB, 3, 3, 0, 0, 0, 8'hCB));
      vecs.push_back(mk(0, 1, 0, 8'h76, CTL_CB_OP,     6, 6, 1, 0, 0, 8'h76)); // CB 76 is BIT, not HALT
`ifdef SM83_ILLEGAL_TRAP_EN
      vecs.push_back(mk(0, 1, 0, 8'hD3, CTL_ILLEGAL,   6, 6, 0, 0, 1, 8'hD3)); // lock
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_ILLEGAL,   6, 6, 0, 0, 1, 8'hD3)); // fetch ignored
      vecs.push_back(mk(0, 0, 1, 8'h00, CTL_ILLEGAL,   6, 6, 0, 0, 1, 8'hD3)); // wake ignored
`else
      vecs.push_back(mk(0, 1, 0, 8'hD3, CTL_NOP,       6, 6, 0, 0, 0, 8'hD3)); // NOP
      vecs.push_back(mk(0, 1, 0, 8'h06, CTL_LD_R8_D8,  0, 6, 0, 0, 0, 8'h06));
      vecs.push_back(mk(0, 0, 1, 8'h00, CTL_LD_R8_D8,  0, 6, 0, 0, 0, 8'h06));
`endif
      vecs.push_back(mk(1, 0, 0, 8'h00, CTL_NOP,       0, 0, 0, 0, 0, 8'h00)); // reset
      vecs.push_back(mk(0, 1, 0, 8'h40, CTL_LD_R8_R8,  0, 0, 0, 0, 0, 8'h40)); // LD B,B
      vecs.push_back(mk(0, 1, 0, 8'h7F, CTL_LD_R8_R8,  7, 7, 0, 0, 0, 8'h7F)); // LD A,A
      vecs.push_back(mk(0, 1, 0, 8'hC3, CTL_NOP,       7, 7, 0, 0, 0, 8'hC3)); // other opcode
      vecs.push_back(mk(0, 1, 0, 8'h36, CTL_LD_R8_D8,  6, 7, 0, 0, 0, 8'h36)); // LD (HL),d8

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].fetch, vecs[i].wake, vecs[i].data);
         check_all($sformatf("vec%0d", i), vecs[i]);
      end

      // Long HALT with a stream of fetch bytes that must all be discarded.
      drive(0, 1, 0, 8'h76);
      check_all("halt_enter", mk(0, 1, 0, 8'h76, CTL_HALT, 6, 7, 0, 1, 0, 8'h76));
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 0, 8'(8'h40 + 8'(k * 9)));
         check_all($sformatf("halt_hold%0d", k), mk(0, 1, 0, 8'h00, CTL_HALT, 6, 7, 0, 1, 0, 8'h76));
      end
      drive(0, 0, 1, 8'h00);
      check_all("halt_wake", mk(0, 0, 1, 8'h00, CTL_NOP, 6, 7, 0, 0, 0, 8'h76));
      drive(0, 1, 0, 8'h5A);
      check_all("after_wake", mk(0, 1, 0, 8'h5A, CTL_LD_R8_R8, 3, 2, 0, 0, 0, 8'h5A));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
